// File: rtl/mdu_ctrl.sv
// Multiply/divide sequencing controller for the EX stage.
// Issues start pulses to an external fixed-latency multiplier and an
// iterative divider, stalls the pipeline while an operation is in flight,
// and presents the captured {hi, lo} result for one cycle (longer if the
// pipeline is stalled elsewhere).
module mdu_ctrl #(
  parameter int MUL_LAT = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ismultE,
  input  logic        signedmultE,
  input  logic        isdivE,
  input  logic        signeddivE,
  input  logic [31:0] srcaE,
  input  logic [31:0] srcbE,
  input  logic        flushE,
  input  logic        stallE,
  output logic        mul_start,
  output logic        mul_signed,
  output logic [31:0] mul_a,
  output logic [31:0] mul_b,
  input  logic [63:0] mul_result,
  output logic        div_start,
  output logic        div_signed,
  output logic        div_annul,
  output logic [31:0] div_a,
  output logic [31:0] div_b,
  input  logic        div_ready,
  input  logic [63:0] div_result,
  output logic        stall_req,
  output logic        hilo_valid,
  output logic [63:0] hilo_out
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] MUL  = 2'd1;
  localparam logic [1:0] DIV  = 2'd2;
  localparam logic [1:0] DONE = 2'd3;

  localparam logic [3:0] LAT = 4'(MUL_LAT);

  logic [1:0]  state;
  logic [3:0]  cnt;
  logic [31:0] aReg;
  logic [31:0] bReg;
  logic        sgnReg;
  logic [63:0] resReg;

  logic mulGo;
  logic divGo;
  logic capMul;
  logic capDiv;

  // Start and capture decisions; a simultaneous mult+div request is a divide.
  // Gating with rst keeps every output low while reset is held.
  always_comb begin
    divGo  = rst && (state == IDLE) && isdivE && !flushE;
    mulGo  = rst && (state == IDLE) && ismultE && !isdivE && !flushE;
    capMul = (state == MUL) && !flushE && (cnt == 4'd1);
    capDiv = (state == DIV) && !flushE && div_ready;
  end

  // Core operands are taken straight from the EX inputs in the start cycle,
  // then from the latched copies so they stay stable while the core works.
  assign mul_start  = mulGo;
  assign div_start  = divGo;
  assign mul_a      = mulGo ? srcaE : aReg;
  assign mul_b      = mulGo ? srcbE : bReg;
  assign div_a      = divGo ? srcaE : aReg;
  assign div_b      = divGo ? srcbE : bReg;
  assign mul_signed = mulGo ? signedmultE : sgnReg;
  assign div_signed = divGo ? signeddivE : sgnReg;

  assign div_annul  = rst && (state == DIV) && flushE;
  assign stall_req  = rst && (mulGo || divGo || (state == MUL) || (state == DIV));
  assign hilo_valid = rst && (state == DONE) && !flushE;
  assign hilo_out   = resReg;

  // FSM, latency counter, operand latches and result register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= IDLE;
      cnt    <= 4'd0;
      aReg   <= 32'd0;
      bReg   <= 32'd0;
      sgnReg <= 1'b0;
      resReg <= 64'd0;
    end else begin
      case (state)
        IDLE: begin
          if (divGo) begin
            aReg   <= srcaE;
            bReg   <= srcbE;
            sgnReg <= signeddivE;
            state  <= DIV;
          end else if (mulGo) begin
            aReg   <= srcaE;
            bReg   <= srcbE;
            sgnReg <= signedmultE;
            cnt    <= LAT;
            state  <= MUL;
          end
        end
        MUL: begin
          if (flushE) begin
            cnt   <= 4'd0;
            state <= IDLE;
          end else if (capMul) begin
            resReg <= mul_result;
            cnt    <= 4'd0;
            state  <= DONE;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        DIV: begin
          if (flushE) begin
            state <= IDLE;
          end else if (capDiv) begin
            resReg <= div_result;
            state  <= DONE;
          end
        end
        DONE: begin
          if (flushE || !stallE) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mdu_ctrl.sv
// Directed bench for mdu_ctrl with MUL_LAT=2; the core responses
// (mul_result, div_ready/div_result) are driven by hand in each step.
module tb_mdu_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        ismultE, signedmultE, isdivE, signeddivE;
  logic [31:0] srcaE, srcbE;
  logic        flushE, stallE;
  logic        mul_start, mul_signed;
  logic [31:0] mul_a, mul_b;
  logic [63:0] mul_result;
  logic        div_start, div_signed, div_annul;
  logic [31:0] div_a, div_b;
  logic        div_ready;
  logic [63:0] div_result;
  logic        stall_req, hilo_valid;
  logic [63:0] hilo_out;

  int checks = 0;
  int errors = 0;

  mdu_ctrl #(.MUL_LAT(2)) dut (
    .clk(clk), .rst(rst),
    .ismultE(ismultE), .signedmultE(signedmultE),
    .isdivE(isdivE), .signeddivE(signeddivE),
    .srcaE(srcaE), .srcbE(srcbE),
    .flushE(flushE), .stallE(stallE),
    .mul_start(mul_start), .mul_signed(mul_signed),
    .mul_a(mul_a), .mul_b(mul_b), .mul_result(mul_result),
    .div_start(div_start), .div_signed(div_signed), .div_annul(div_annul),
    .div_a(div_a), .div_b(div_b),
    .div_ready(div_ready), .div_result(div_result),
    .stall_req(stall_req), .hilo_valid(hilo_valid), .hilo_out(hilo_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge, then let comb logic settle.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  initial begin
    rst = 1'b0;
    ismultE = 1'b1; signedmultE = 1'b1; isdivE = 1'b0; signeddivE = 1'b0;
    srcaE = 32'h1234_5678; srcbE = 32'h9; flushE = 1'b0; stallE = 1'b0;
    mul_result = 64'hDEAD_BEEF_0000_0001; div_ready = 1'b0; div_result = 64'd0;
    tick(); tick();
    // Reset: outputs low even with a mult request present
    chk("rst_mul_start", mul_start, 0);
    chk("rst_stall", stall_req, 0);
    chk("rst_hilo_valid", hilo_valid, 0);
    chk("rst_hilo_out", hilo_out, 0);
    chk("rst_mul_a", mul_a, 0);

    // Signed mult 0xFFFFFFFE * 3, accepted in first cycle after reset release
    rst = 1'b1; srcaE = 32'hFFFF_FFFE; srcbE = 32'd3;
    settle();
    chk("m1_start", mul_start, 1);
    chk("m1_stall0", stall_req, 1);
    chk("m1_a", mul_a, 32'hFFFF_FFFE);
    chk("m1_signed", mul_signed, 1);
    tick();
    ismultE = 1'b0; srcaE = 32'h5555_5555; srcbE = 32'h0;
    settle();
    chk("m1_start_pulse", mul_start, 0);
    chk("m1_stall1", stall_req, 1);
    chk("m1_a_stable", mul_a, 32'hFFFF_FFFE);
    chk("m1_b_stable", mul_b, 3);
    tick();
    mul_result = 64'hFFFF_FFFF_FFFF_FFFA;
    settle();
    chk("m1_stall2", stall_req, 1);
    chk("m1_no_valid", hilo_valid, 0);
    tick();
    mul_result = 64'h0123_4567_89AB_CDEF;
    settle();
    chk("m1_valid", hilo_valid, 1);
    chk("m1_out", hilo_out, 64'hFFFF_FFFF_FFFF_FFFA);
    chk("m1_done_stall", stall_req, 0);
    tick();
    chk("m1_valid_pulse", hilo_valid, 0);
    chk("m1_out_held", hilo_out, 64'hFFFF_FFFF_FFFF_FFFA);

    // Unsigned divide 100 / 7 -> {2, 14}
    isdivE = 1'b1; signeddivE = 1'b0; srcaE = 32'd100; srcbE = 32'd7;
    settle();
    chk("d1_start", div_start, 1);
    chk("d1_signed", div_signed, 0);
    chk("d1_a", div_a, 100);
    chk("d1_stall0", stall_req, 1);
    tick();
    isdivE = 1'b0; srcaE = 32'd0; srcbE = 32'd0;
    for (int i = 0; i < 32; i++) begin
      settle();
      chk("d1_stall_wait", stall_req, 1);
      chk("d1_b_stable", div_b, 7);
      tick();
    end
    div_ready = 1'b1; div_result = {32'd2, 32'd14};
    settle();
    chk("d1_stall_ready", stall_req, 1);
    chk("d1_no_valid", hilo_valid, 0);
    tick();
    div_ready = 1'b0; div_result = 64'd0;
    settle();
    chk("d1_valid", hilo_valid, 1);
    chk("d1_out", hilo_out, 64'h0000_0002_0000_000E);
    tick();
    chk("d1_valid_pulse", hilo_valid, 0);

    // mult+div together is a divide; then flush it in its 5th cycle
    ismultE = 1'b1; isdivE = 1'b1; signeddivE = 1'b1; srcaE = 32'd50; srcbE = 32'd5;
    settle();
    chk("both_div_start", div_start, 1);
    chk("both_no_mul_start", mul_start, 0);
    tick();
    ismultE = 1'b0; isdivE = 1'b0;
    tick(); tick(); tick();
    flushE = 1'b1; div_ready = 1'b1; div_result = 64'h1111_1111_2222_2222;
    settle();
    chk("fl_div_annul", div_annul, 1);
    tick();
    flushE = 1'b0;
    settle();
    chk("fl_annul_pulse", div_annul, 0);
    chk("fl_idle_stall", stall_req, 0);
    chk("fl_no_valid", hilo_valid, 0);
    tick();
    div_ready = 1'b0;
    settle();
    chk("fl_no_valid2", hilo_valid, 0);
    chk("fl_out_held", hilo_out, 64'h0000_0002_0000_000E);

    // Unsigned mult 5*6 completing under an external stall of 3 cycles
    ismultE = 1'b1; signedmultE = 1'b0; srcaE = 32'd5; srcbE = 32'd6;
    settle();
    chk("m2_start", mul_start, 1);
    chk("m2_signed", mul_signed, 0);
    tick();
    ismultE = 1'b0;
    tick();
    mul_result = 64'd30;
    tick();
    mul_result = 64'hFFFF_0000_FFFF_0000;
    ismultE = 1'b1; srcaE = 32'd7; srcbE = 32'd8;
    for (int i = 0; i < 4; i++) begin
      stallE = (i < 3);
      settle();
      chk("m2_valid_hold", hilo_valid, 1);
      chk("m2_out_hold", hilo_out, 30);
      chk("m2_no_start", mul_start, 0);
      chk("m2_no_stall", stall_req, 0);
      tick();
    end
    ismultE = 1'b0; stallE = 1'b0;
    settle();
    chk("m2_release", hilo_valid, 0);

    // Flush in MUL: later product ignored
    ismultE = 1'b1; srcaE = 32'd9; srcbE = 32'd9;
    tick();
    ismultE = 1'b0; flushE = 1'b1;
    settle();
    chk("fm_stall", stall_req, 1);
    tick();
    flushE = 1'b0; mul_result = 64'd81;
    settle();
    chk("fm_idle", stall_req, 0);
    tick();
    chk("fm_no_valid", hilo_valid, 0);
    chk("fm_out_held", hilo_out, 30);

    // Flush in DONE: hilo_valid dropped that cycle
    ismultE = 1'b1; srcaE = 32'd2; srcbE = 32'd3;
    tick();
    ismultE = 1'b0;
    tick();
    mul_result = 64'd6;
    tick();
    flushE = 1'b1; stallE = 1'b1;
    settle();
    chk("fd_valid_low", hilo_valid, 0);
    chk("fd_out", hilo_out, 6);
    tick();
    flushE = 1'b0; stallE = 1'b0;
    settle();
    chk("fd_idle_valid", hilo_valid, 0);
    chk("fd_idle_stall", stall_req, 0);

    // mult request killed in IDLE
    ismultE = 1'b1; flushE = 1'b1;
    settle();
    chk("fi_no_start", mul_start, 0);
    chk("fi_no_stall", stall_req, 0);
    tick();
    ismultE = 1'b0; flushE = 1'b0;
    settle();
    chk("fi_idle", stall_req, 0);
    chk("fi_no_valid", hilo_valid, 0);

    // Reset mid-DIV, with flush pending: no annul, everything zero
    isdivE = 1'b1; srcaE = 32'd9; srcbE = 32'd3;
    tick();
    isdivE = 1'b0;
    tick();
    flushE = 1'b1; div_ready = 1'b1; div_result = 64'h0000_0000_0000_0003;
    #2;
    rst = 1'b0;
    #1;
    chk("rd_stall", stall_req, 0);
    chk("rd_annul", div_annul, 0);
    chk("rd_div_a", div_a, 0);
    chk("rd_hilo_out", hilo_out, 0);
    chk("rd_valid", hilo_valid, 0);
    tick();
    rst = 1'b1; flushE = 1'b0; ismultE = 1'b1; signedmultE = 1'b1;
    srcaE = 32'd4; srcbE = 32'd4;
    settle();
    chk("rd_mul_start", mul_start, 1);
    chk("rd_no_div_start", div_start, 0);
    tick();
    ismultE = 1'b0; div_ready = 1'b0;
    tick();
    mul_result = 64'd16;
    tick();
    settle();
    chk("rd_m_valid", hilo_valid, 1);
    chk("rd_m_out", hilo_out, 16);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
